sd_cmd_responder: RTL
=====================

# sd_cmd_responder

Card-side endpoint of the SD CMD line; the host-side command path is the initiator on the same wire. Receives 48-bit command frames, checks framing and CRC7, reports the decoded command, and answers with an R1 (48-bit) or R2 (136-bit, CID) response. Used as the card model in host-controller benches and in FPGA loopback builds. Bit timing comes from a per-bit strobe produced by the existing clock-divider counter.

## Interface
- NCR, 2, idle bit periods between command end bit and response start bit; legal 2..64
- ex_clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; one clock, no other clocks
- bit_en  in  1  one-cycle strobe per SD bit period; strobes ≥3 ex_clk apart
- cmd_in  in  1  CMD line as seen at the pad; sampled only on bit_en cycles
- cmd_out  out  1  bit driven onto CMD when cmd_oe=1
- cmd_oe  out  1  CMD output enable (line released when 0)
- cid_reg  in  128  CID register; bits [7:1] already hold its CRC7
- card_status  in  32  card status word returned in R1
- cmd_valid  out  1  one-cycle pulse: good command received
- cmd_index  out  6  index of last good command; held until next
- cmd_arg  out  32  argument of last good command; held until next
- crc_err  out  1  one-cycle pulse: bad CRC, transmission bit, or end bit
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, RX, CHECK, WAIT, TX.
- IDLE: on bit_en with cmd_in=0 → RX; start bit counts as bit 1.
- RX: shift cmd_in into 48-bit register MSB-first on each bit_en; serial CRC7 (x^7+x^3+1) over bits 1..40. After bit 48 → CHECK.
- CHECK (one ex_clk): pass = bit 2 (transmission)=1 AND bits 41..47 = computed CRC7 AND bit 48=1.
  - Fail: crc_err pulse, → IDLE, no response, cmd_index/cmd_arg unchanged.
  - Pass: cmd_valid pulse, cmd_index/cmd_arg updated same cycle.
  - Index 0 → IDLE (no response).
  - Index 2 or 10 → load R2: 0,0,6'b111111,cid_reg[127:1],1 (136 bits), → WAIT.
  - Any other index → load R1 head: 0,0,cmd_index,card_status (40 bits), → WAIT.
  - cid_reg/card_status sampled only in CHECK; later changes do not affect the response.
- WAIT: line released; count NCR bit_en strobes, then → TX.
- TX: on each bit_en drive next bit MSB-first with cmd_oe=1. R1: first 40 bits feed serial CRC7; bits 41..47 = CRC7, bit 48 = 1. R2: bits sent verbatim. Strobe after the last bit: cmd_oe=0, cmd_out=1, → IDLE.
- cmd_in ignored in WAIT and TX (no collision detection); a new start bit is only recognised from IDLE.
- Reset (any state, mid-frame included): immediate return to IDLE, CMD released, partial frame discarded.

## Timing
- Reset values: cmd_out=1, cmd_oe=0, cmd_valid=0, crc_err=0, cmd_index=0, cmd_arg=0, busy=0.
- All outputs registered; changes take effect the ex_clk cycle after the bit_en cycle that causes them.
- cmd_valid/crc_err: asserted exactly 2 ex_clk after the bit_en that sampled the end bit.
- Response start bit driven on the (NCR+1)th bit_en after the command end-bit strobe.
- cmd_oe high for exactly 48 (R1) or 136 (R2) bit periods.
- busy rises the cycle after the start-bit strobe and falls with cmd_oe (or after CHECK for no-response/error).

## Structure
- Shared package sd_pkg: state enum, frame lengths (48, 136), CMD_GO_IDLE=0, CMD_ALL_SEND_CID=2, CMD_SEND_CID=10, CRC7 polynomial constant.
- Sub-module sd_crc7: serial CRC7 generator (ex_clk, reset, clear, en, din → crc[6:0]); one instance shared by RX and TX, cleared on start-bit detect and on TX entry.

## Test plan
- CMD0 frame 0x40_00000000_95 → cmd_valid, cmd_index=0, cmd_arg=0, cmd_oe stays 0.
- CMD8 frame 0x48_000001AA_87, card_status=0x00000120 → cmd_arg=0x000001AA; R1 starts with 0x08,0x00000120, CRC7 matches model, start bit on 3rd strobe after end bit (NCR=2).
- CMD2 frame 0x42_00000000_4D, known cid_reg → 136-bit R2, first byte 0x3F, bits 9..135 = cid_reg[127:1], end bit 1.
- CMD17 frame with CRC byte 0x57 instead of 0x55 → crc_err pulse, no cmd_valid, cmd_index/cmd_arg keep prior values, no response.
- Good frame with end bit 0 → crc_err; then valid CMD17 0x51_00000000_55 accepted normally.
- reset asserted mid-RX and mid-TX → cmd_oe=0, cmd_out=1, busy=0 immediately; next frame after release decoded correctly.

Source files
------------

// File: rtl/sd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : sd_pkg                                                     |
// | Shared definitions for the SD CMD-line card responder: controller   |
// | state encoding, frame lengths, command indices, CRC7 polynomial.     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RX    = 3'd1,
    ST_CHECK = 3'd2,
    ST_WAIT  = 3'd3,
    ST_TX    = 3'd4
  } sd_state_e;

  localparam int CMD_FRAME_LEN    = 48;   // command and R1 frame length
  localparam int R2_FRAME_LEN     = 136;  // R2 (CID) frame length
  localparam int CRC_DATA_LEN     = 40;   // bits covered by CRC7 in a 48-bit frame

  localparam int CMD_GO_IDLE      = 0;
  localparam int CMD_ALL_SEND_CID = 2;
  localparam int CMD_SEND_CID     = 10;

  // x^7 + x^3 + 1 with the x^7 term implied
  localparam logic [6:0] CRC7_POLY = 7'h09;

  // Commands answered with the long CID response
  function automatic logic is_r2_index(input logic [5:0] idx);
    return (idx == 6'(CMD_ALL_SEND_CID)) || (idx == 6'(CMD_SEND_CID));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_cmd_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : sd_cmd_responder_if                                      |
// | CMD-line and command-report signals of the SD card responder.        |
// |   slave  : the responder (card side)                                 |
// |   master : the environment (host model / bench)                      |
// | Signals: bit_en, cmd_in, cmd_out, cmd_oe, cid_reg, card_status,      |
// |          cmd_valid, cmd_index, cmd_arg, crc_err, busy                |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface sd_cmd_responder_if;
  logic         bit_en;
  logic         cmd_in;
  logic         cmd_out;
  logic         cmd_oe;
  logic [127:0] cid_reg;
  logic [31:0]  card_status;
  logic         cmd_valid;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic         crc_err;
  logic         busy;

  modport slave (
    input  bit_en, cmd_in, cid_reg, card_status,
    output cmd_out, cmd_oe, cmd_valid, cmd_index, cmd_arg, crc_err, busy
  );

  modport master (
    output bit_en, cmd_in, cid_reg, card_status,
    input  cmd_out, cmd_oe, cmd_valid, cmd_index, cmd_arg, crc_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/sd_crc7.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sd_crc7                                                     |
// | Serial CRC7 (x^7+x^3+1) generator, one bit per enabled cycle, MSB    |
// | of the message first.                                                |
// | Ports: ex_clk, reset (async, active-low), clear (sync, wins over en),|
// |        en, din -> crc[6:0]                                           |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module sd_crc7
  import sd_pkg::*;
(
  input  logic       ex_clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_q;
  logic       w_fb;

  assign w_fb = din ^ crc_q[6];

  always_ff @(posedge ex_clk or negedge reset) begin
    if (!reset) begin
      crc_q <= '0;
    end else if (clear) begin
      crc_q <= '0;
    end else if (en) begin
      crc_q <= {crc_q[5:0], 1'b0} ^ (w_fb ? CRC7_POLY : 7'h00);
    end
  end

  assign crc = crc_q;

endmodule
`default_nettype wire

// File: rtl/sd_cmd_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sd_cmd_responder                                            |
// | Card-side SD CMD-line endpoint. Receives 48-bit command frames,      |
// | checks transmission bit, CRC7 and end bit, reports the command and   |
// | answers with R1 (48 bits) or R2 (136 bits, CID) after NCR idle bits. |
// | Ports: ex_clk  system clock                                          |
// |        reset   asynchronous active-low reset                         |
// |        bus     sd_cmd_responder_if.slave (CMD line + command report) |
// | Parameter: NCR idle bit periods before the response (2..64)         |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module sd_cmd_responder
  import sd_pkg::*;
#(
  parameter int NCR = 2
) (
  input  logic                 ex_clk,
  input  logic                 reset,
  sd_cmd_responder_if.slave    bus
);

  sd_state_e     state_q;
  logic [47:0]   rx_q;
  logic [5:0]    rx_cnt_q;      // frame bits received so far, start bit included
  logic [6:0]    wait_cnt_q;
  logic [135:0]  tx_q;          // response, left aligned, shifted out MSB first
  logic [7:0]    tx_cnt_q;      // response bits already driven
  logic          tx_r2_q;

  logic          cmd_out_q;
  logic          cmd_oe_q;
  logic          cmd_valid_q;
  logic          crc_err_q;
  logic [5:0]    cmd_index_q;
  logic [31:0]   cmd_arg_q;
  logic          busy_q;

  logic [6:0]    w_crc;
  logic          w_crc_clear;
  logic          w_crc_en;
  logic          w_crc_din;
  logic          w_pass;
  logic [5:0]    w_idx;
  logic [31:0]   w_arg;
  logic          w_is_r2;
  logic          w_wait_done;
  logic [7:0]    w_tx_len;
  logic          w_tx_bit;
  logic [1:0]    w_unused;

  // Frame layout in rx_q: bit 1 (start) at [47], bit 48 (end) at [0]
  assign w_idx   = rx_q[45:40];
  assign w_arg   = rx_q[39:8];
  assign w_pass  = rx_q[46] && (rx_q[7:1] == w_crc) && rx_q[0];
  assign w_is_r2 = is_r2_index(w_idx);

  // Start bit is always 0 here; the CID CRC/spare bit is replaced by our own end bit
  assign w_unused = {rx_q[47], bus.cid_reg[0]};

  assign w_wait_done = (wait_cnt_q == 7'(NCR - 1));
  assign w_tx_len    = tx_r2_q ? 8'(R2_FRAME_LEN) : 8'(CMD_FRAME_LEN);

  // R1 tail is generated here: CRC7 of the first 40 bits, then the end bit.
  // For tx_cnt 40..46 the low three bits of the count run 0..6 because 40 is
  // a multiple of 8, so they select the CRC bit directly.
  always_comb begin
    w_tx_bit = tx_q[135];
    if (!tx_r2_q && (tx_cnt_q >= 8'(CRC_DATA_LEN))) begin
      if (tx_cnt_q >= 8'(CMD_FRAME_LEN - 1)) begin
        w_tx_bit = 1'b1;
      end else begin
        w_tx_bit = w_crc[3'd6 - tx_cnt_q[2:0]];
      end
    end
  end

  // One CRC engine serves both directions: cleared on the start bit (the start
  // bit is 0 so skipping it leaves the register unchanged) and on TX entry.
  assign w_crc_clear = bus.bit_en &&
                       (((state_q == ST_IDLE) && !bus.cmd_in) ||
                        ((state_q == ST_WAIT) && w_wait_done));
  assign w_crc_en    = bus.bit_en &&
                       (((state_q == ST_RX) && (rx_cnt_q < 6'(CRC_DATA_LEN))) ||
                        ((state_q == ST_TX) && !tx_r2_q && (tx_cnt_q < 8'(CRC_DATA_LEN))));
  assign w_crc_din   = (state_q == ST_RX) ? bus.cmd_in : w_tx_bit;

  sd_crc7 u_crc7 (
    .ex_clk (ex_clk),
    .reset  (reset),
    .clear  (w_crc_clear),
    .en     (w_crc_en),
    .din    (w_crc_din),
    .crc    (w_crc)
  );

  always_ff @(posedge ex_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rx_q        <= '0;
      rx_cnt_q    <= '0;
      wait_cnt_q  <= '0;
      tx_q        <= '0;
      tx_cnt_q    <= '0;
      tx_r2_q     <= 1'b0;
      cmd_out_q   <= 1'b1;
      cmd_oe_q    <= 1'b0;
      cmd_valid_q <= 1'b0;
      crc_err_q   <= 1'b0;
      cmd_index_q <= '0;
      cmd_arg_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      crc_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.bit_en && !bus.cmd_in) begin
            state_q  <= ST_RX;
            rx_q     <= '0;          // start bit already in place at [0]
            rx_cnt_q <= 6'd1;
            busy_q   <= 1'b1;
          end
        end

        ST_RX: begin
          if (bus.bit_en) begin
            rx_q     <= {rx_q[46:0], bus.cmd_in};
            rx_cnt_q <= rx_cnt_q + 6'd1;
            if (rx_cnt_q == 6'(CMD_FRAME_LEN - 1)) begin
              state_q <= ST_CHECK;
            end
          end
        end

        ST_CHECK: begin
          if (!w_pass) begin
            crc_err_q <= 1'b1;
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
          end else begin
            cmd_valid_q <= 1'b1;
            cmd_index_q <= w_idx;
            cmd_arg_q   <= w_arg;
            if (w_idx == 6'(CMD_GO_IDLE)) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q    <= ST_WAIT;
              wait_cnt_q <= '0;
              tx_r2_q    <= w_is_r2;
              tx_q       <= w_is_r2 ?
                            {2'b00, 6'b111111, bus.cid_reg[127:1], 1'b1} :
                            {2'b00, w_idx, bus.card_status, 96'd0};
            end
          end
        end

        ST_WAIT: begin
          if (bus.bit_en) begin
            if (w_wait_done) begin
              state_q  <= ST_TX;
              tx_cnt_q <= '0;
            end else begin
              wait_cnt_q <= wait_cnt_q + 7'd1;
            end
          end
        end

        ST_TX: begin
          if (bus.bit_en) begin
            if (tx_cnt_q == w_tx_len) begin
              cmd_oe_q  <= 1'b0;
              cmd_out_q <= 1'b1;
              state_q   <= ST_IDLE;
              busy_q    <= 1'b0;
            end else begin
              cmd_oe_q  <= 1'b1;
              cmd_out_q <= w_tx_bit;
              tx_q      <= {tx_q[134:0], 1'b0};
              tx_cnt_q  <= tx_cnt_q + 8'd1;
            end
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          cmd_oe_q  <= 1'b0;
          cmd_out_q <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_out   = cmd_out_q;
  assign bus.cmd_oe    = cmd_oe_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.crc_err   = crc_err_q;
  assign bus.cmd_index = cmd_index_q;
  assign bus.cmd_arg   = cmd_arg_q;
  assign bus.busy      = busy_q;

endmodule
`default_nettype wire
